waterbear_core: RTL and testbench

// Parametrised multi-cycle accumulator CPU; next generation of the waterbear core.

---
 rtl/waterbear_pkg.sv | 34 +++
 rtl/waterbear_wmem.sv | 24 ++
 rtl/waterbear_core.sv | 191 +++++++++++++++++++
 tb/tb_waterbear_core.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waterbear_pkg.sv
// Shared opcode, FSM state and instruction-field helpers for the waterbear core.
package waterbear_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDR = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_EQU = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd7;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH     = 3'd0;
  localparam state_t ST_DECODE    = 3'd1;
  localparam state_t ST_EXECUTE   = 3'd2;
  localparam state_t ST_WRITEBACK = 3'd3;
  localparam state_t ST_HALT      = 3'd4;

  // Instruction layout, LSB first: operand, imm flag, 4-bit opcode, reserved.
  function automatic int unsigned imm_bit(input int unsigned opnd_w);
    return opnd_w;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned opnd_w);
    return opnd_w + 1;
  endfunction

  function automatic int unsigned field_w(input int unsigned opnd_w);
    return opnd_w + 5;
  endfunction

endpackage

// File: rtl/waterbear_wmem.sv
// Work memory: one synchronous write port, one asynchronous read port, no reset.
module waterbear_wmem #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/waterbear_core.sv
// Multi-cycle accumulator CPU: FETCH -> DECODE -> EXECUTE -> WRITEBACK, HALT terminal.
module waterbear_core
  import waterbear_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned OPND_W  = 6,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_valid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [DATA_W-1:0]  acc_o,
  output logic               flag_z_o,
  output logic               flag_c_o,
  output logic               halted_o
);

  localparam int unsigned FieldW = field_w(OPND_W);
  localparam int unsigned ImmBit = imm_bit(OPND_W);
  localparam int unsigned OpLsb  = op_lsb(OPND_W);

  state_t              state_q, state_d;
  logic [FieldW-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic                req_en_q, req_en_d;
  logic [3:0]          op_q, op_d;
  logic                imm_q, imm_d;
  logic [OPND_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                res_z_q, res_z_d;
  logic                res_c_q, res_c_d;
  logic                jmp_q, jmp_d;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   wmem_rdata;
  logic                wmem_we;

  if (INSTR_W > FieldW) begin : g_rsvd
    logic unused_rsvd;
    assign unused_rsvd = ^imem_rdata_i[INSTR_W-1:FieldW];
  end

  // Request held low for the first cycle out of reset so a stale response is dropped.
  assign imem_req_o  = (state_q == ST_FETCH) && req_en_q;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign acc_o       = acc_q;
  assign flag_z_o    = z_q;
  assign flag_c_o    = c_q;
  assign halted_o    = (state_q == ST_HALT);

  assign sum     = {1'b0, acc_q} + {1'b0, val_q};
  assign diff    = {1'b0, acc_q} - {1'b0, val_q};
  assign wmem_we = (state_q == ST_WRITEBACK) && (op_q == OP_STR);

  waterbear_wmem #(
    .AW (OPND_W),
    .DW (DATA_W)
  ) u_wmem (
    .clk_i   (clk_i),
    .we_i    (wmem_we),
    .waddr_i (opnd_q),
    .wdata_i (acc_q),
    .raddr_i (ir_q[OPND_W-1:0]),
    .rdata_o (wmem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    z_d      = z_q;
    c_d      = c_q;
    req_en_d = 1'b1;
    op_d     = op_q;
    imm_d    = imm_q;
    opnd_d   = opnd_q;
    val_d    = val_q;
    res_d    = res_q;
    res_z_d  = res_z_q;
    res_c_d  = res_c_q;
    jmp_d    = jmp_q;

    case (state_q)
      ST_FETCH: begin
        if (imem_req_o && imem_valid_i) begin
          ir_d    = imem_rdata_i[FieldW-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        op_d    = ir_q[OpLsb +: 4];
        imm_d   = ir_q[ImmBit];
        opnd_d  = ir_q[OPND_W-1:0];
        val_d   = ir_q[ImmBit] ? DATA_W'(ir_q[OPND_W-1:0]) : wmem_rdata;
        state_d = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        res_d   = acc_q;
        res_z_d = z_q;
        res_c_d = c_q;
        case (op_q)
          OP_LDR: begin
            res_d   = val_q;
            res_z_d = (val_q == '0);
          end
          OP_ADD: begin
            res_d   = sum[DATA_W-1:0];
            res_z_d = (sum[DATA_W-1:0] == '0);
            res_c_d = sum[DATA_W];
          end
          OP_SUB: begin
            res_d   = diff[DATA_W-1:0];
            res_z_d = (diff[DATA_W-1:0] == '0);
            res_c_d = diff[DATA_W];
          end
          OP_EQU: res_z_d = (acc_q == val_q);
          default: ;
        endcase
        jmp_d   = (op_q == OP_JMP) && (!imm_q || z_q);
        state_d = ST_WRITEBACK;
      end

      ST_WRITEBACK: begin
        // Non-ALU ops carry the held acc/flags through res_*, so commit is uniform.
        acc_d = res_q;
        z_d   = res_z_q;
        c_d   = res_c_q;
        if (jmp_q) begin
          pc_d = ADDR_W'(opnd_q);
        end
        state_d = (op_q == OP_HLT) ? ST_HALT : ST_FETCH;
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      pc_q     <= '0;
      acc_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      req_en_q <= 1'b0;
      op_q     <= OP_NOP;
      imm_q    <= 1'b0;
      opnd_q   <= '0;
      val_q    <= '0;
      res_q    <= '0;
      res_z_q  <= 1'b0;
      res_c_q  <= 1'b0;
      jmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      req_en_q <= req_en_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      opnd_q   <= opnd_d;
      val_q    <= val_d;
      res_q    <= res_d;
      res_z_q  <= res_z_d;
      res_c_q  <= res_c_d;
      jmp_q    <= jmp_d;
    end
  end

endmodule

// File: tb/tb_waterbear_core.sv
// Directed scoreboard bench for waterbear_core with a wait-state program memory model.
module tb_waterbear_core;
  import waterbear_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [7:0]  pc;
  logic [7:0]  acc;
  logic        flag_z, flag_c, halted;

  logic [15:0] prog [256];
  int unsigned wait_cycles = 0;
  int unsigned wcnt = 0;
  logic        valid_pulse = 1'b0;

  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  int          cyc = 0;
  int          fetch_t[$];
  logic [7:0]  fetch_a[$];
  int          addr_glitch = 0;
  logic        holding = 1'b0;
  logic [7:0]  hold_addr = '0;

  waterbear_core #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .OPND_W  (6),
    .INSTR_W (16)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_valid_i (imem_valid),
    .imem_rdata_i (imem_rdata),
    .pc_o         (pc),
    .acc_o        (acc),
    .flag_z_o     (flag_z),
    .flag_c_o     (flag_c),
    .halted_o     (halted)
  );

  always #5 clk = ~clk;

  assign imem_valid = (imem_req && (wcnt >= wait_cycles)) || valid_pulse;
  assign imem_rdata = prog[imem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req && !imem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (imem_req && imem_valid) begin
      fetch_t.push_back(cyc);
      fetch_a.push_back(imem_addr);
    end
    if (holding && imem_req && (imem_addr !== hold_addr)) addr_glitch <= addr_glitch + 1;
    holding   <= imem_req && !imem_valid;
    hold_addr <= imem_addr;
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic imm,
                                      input logic [5:0] opnd);
    return {5'b0, op, imm, opnd};
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb.push_back(s);
  endtask

  task automatic observe(input string tag, input logic [31:0] obs);
    sb_t s;
    n_chk++;
    if (sb.size() == 0) begin
      s.tag = "empty";
      s.exp = 32'hdead_beef;
    end else begin
      s = sb.pop_front();
    end
    assert (obs === s.exp && s.tag == tag) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (entry %s)", tag, obs, s.exp, s.tag);
    end
  endtask

  task automatic clear_prog(input logic [3:0] op);
    for (int i = 0; i < 256; i++) prog[i] = enc(op, 1'b0, 6'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    fetch_t.delete();
    fetch_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic spacing(output int mn, output int mx);
    mn = 1000;
    mx = 0;
    for (int i = 1; i < fetch_t.size(); i++) begin
      if (fetch_t[i] - fetch_t[i-1] < mn) mn = fetch_t[i] - fetch_t[i-1];
      if (fetch_t[i] - fetch_t[i-1] > mx) mx = fetch_t[i] - fetch_t[i-1];
    end
  endtask

  task automatic load_sum_prog(input logic [5:0] a, input logic [5:0] b);
    clear_prog(OP_NOP);
    prog[0] = enc(OP_LDR, 1'b1, a);
    prog[1] = enc(OP_STR, 1'b0, 6'd13);
    prog[2] = enc(OP_LDR, 1'b1, b);
    prog[3] = enc(OP_STR, 1'b0, 6'd14);
    prog[4] = enc(OP_LDR, 1'b0, 6'd13);
    prog[5] = enc(OP_ADD, 1'b0, 6'd14);
    prog[6] = enc(OP_STR, 1'b0, 6'd15);
    prog[7] = enc(OP_HLT, 1'b0, 6'd0);
  endtask

  initial begin
    int mn, mx;
    bit wrap_seen;

    // Store/load/add program with zero wait states.
    load_sum_prog(6'd5, 6'd7);
    wait_cycles = 0;
    expect_val("p1_halted", 1);
    expect_val("p1_acc", 12);
    expect_val("p1_wmem15", 12);
    expect_val("p1_pc", 8);
    expect_val("p1_c", 0);
    expect_val("p1_z", 0);
    expect_val("p1_sp_min", 4);
    expect_val("p1_sp_max", 4);
    expect_val("p1_req_halt", 0);
    expect_val("p1_pc_frozen", 8);
    expect_val("p1_acc_frozen", 12);
    do_reset();
    run_halt(300);
    observe("p1_halted", halted);
    observe("p1_acc", acc);
    observe("p1_wmem15", u_dut.u_wmem.mem_q[15]);
    observe("p1_pc", pc);
    observe("p1_c", flag_c);
    observe("p1_z", flag_z);
    spacing(mn, mx);
    observe("p1_sp_min", mn);
    observe("p1_sp_max", mx);
    observe("p1_req_halt", imem_req);
    repeat (6) @(negedge clk);
    observe("p1_pc_frozen", pc);
    observe("p1_acc_frozen", acc);

    // 200 + 60 wraps to 4 with carry.
    clear_prog(OP_NOP);
    prog[0] = enc(OP_LDR, 1'b1, 6'd50);
    for (int i = 1; i < 4; i++) prog[i] = enc(OP_ADD, 1'b1, 6'd50);
    prog[4] = enc(OP_ADD, 1'b1, 6'd60);
    prog[5] = enc(OP_HLT, 1'b0, 6'd0);
    expect_val("add_acc", 4);
    expect_val("add_c", 1);
    expect_val("add_z", 0);
    do_reset();
    run_halt(300);
    observe("add_acc", acc);
    observe("add_c", flag_c);
    observe("add_z", flag_z);

    // Then 4 - 5 borrows to 255.
    prog[5] = enc(OP_SUB, 1'b1, 6'd5);
    prog[6] = enc(OP_HLT, 1'b0, 6'd0);
    expect_val("sub_acc", 255);
    expect_val("sub_c", 1);
    expect_val("sub_z", 0);
    do_reset();
    run_halt(300);
    observe("sub_acc", acc);
    observe("sub_c", flag_c);
    observe("sub_z", flag_z);

    // Subtract to exactly zero: z set, no borrow.
    clear_prog(OP_NOP);
    prog[0] = enc(OP_LDR, 1'b1, 6'd1);
    prog[1] = enc(OP_SUB, 1'b1, 6'd1);
    prog[2] = enc(OP_HLT, 1'b0, 6'd0);
    expect_val("zero_acc", 0);
    expect_val("zero_z", 1);
    expect_val("zero_c", 0);
    do_reset();
    run_halt(300);
    observe("zero_acc", acc);
    observe("zero_z", flag_z);
    observe("zero_c", flag_c);

    // Conditional jump taken / not taken.
    for (int k = 0; k < 2; k++) begin
      clear_prog(OP_NOP);
      prog[0] = enc(OP_LDR, 1'b1, 6'd3);
      prog[1] = enc(OP_EQU, 1'b1, (k == 0) ? 6'd3 : 6'd4);
      prog[2] = enc(OP_JMP, 1'b1, 6'd6);
      prog[3] = enc(OP_LDR, 1'b1, 6'd9);
      prog[4] = enc(OP_HLT, 1'b0, 6'd0);
      prog[6] = enc(OP_HLT, 1'b0, 6'd0);
      expect_val("jmp_target", (k == 0) ? 6 : 3);
      expect_val("jmp_pc", (k == 0) ? 7 : 5);
      expect_val("jmp_acc", (k == 0) ? 3 : 9);
      expect_val("jmp_z", (k == 0) ? 1 : 0);
      do_reset();
      run_halt(300);
      observe("jmp_target", (fetch_a.size() > 3) ? fetch_a[3] : 8'hxx);
      observe("jmp_pc", pc);
      observe("jmp_acc", acc);
      observe("jmp_z", flag_z);
    end

    // Run off the top of program space: pc wraps 255 -> 0; opcode 12 is a NOP.
    clear_prog(OP_NOP);
    prog[0] = enc(OP_ADD, 1'b1, 6'd1);
    prog[1] = enc(OP_EQU, 1'b1, 6'd2);
    prog[2] = enc(OP_JMP, 1'b1, 6'd5);
    prog[3] = enc(OP_JMP, 1'b0, 6'd63);
    prog[4] = enc(4'd9, 1'b1, 6'd1);
    prog[5] = enc(OP_HLT, 1'b0, 6'd0);
    for (int i = 63; i < 256; i++) prog[i] = enc(4'd12, i[0], i[5:0]);
    expect_val("wrap_seen", 1);
    expect_val("wrap_acc", 2);
    expect_val("wrap_pc", 6);
    expect_val("wrap_z", 1);
    do_reset();
    run_halt(3000);
    wrap_seen = 1'b0;
    for (int i = 1; i < fetch_a.size(); i++)
      if (fetch_a[i-1] == 8'd255 && fetch_a[i] == 8'd0) wrap_seen = 1'b1;
    observe("wrap_seen", wrap_seen);
    observe("wrap_acc", acc);
    observe("wrap_pc", pc);
    observe("wrap_z", flag_z);

    // Three wait states per fetch.
    load_sum_prog(6'd9, 6'd30);
    wait_cycles = 3;
    expect_val("w3_halted", 1);
    expect_val("w3_acc", 39);
    expect_val("w3_wmem15", 39);
    expect_val("w3_sp_min", 7);
    expect_val("w3_sp_max", 7);
    expect_val("w3_addr_glitch", 0);
    addr_glitch = 0;
    do_reset();
    run_halt(400);
    observe("w3_halted", halted);
    observe("w3_acc", acc);
    observe("w3_wmem15", u_dut.u_wmem.mem_q[15]);
    spacing(mn, mx);
    observe("w3_sp_min", mn);
    observe("w3_sp_max", mx);
    observe("w3_addr_glitch", addr_glitch);

    // Asynchronous reset from a halted, non-zero state.
    expect_val("rst_pc", 0);
    expect_val("rst_acc", 0);
    expect_val("rst_z", 0);
    expect_val("rst_c", 0);
    expect_val("rst_halted", 0);
    expect_val("rst_req", 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    observe("rst_pc", pc);
    observe("rst_acc", acc);
    observe("rst_z", flag_z);
    observe("rst_c", flag_c);
    observe("rst_halted", halted);
    observe("rst_req", imem_req);

    // Reset mid-wait, then a stray valid in the first cycle out of reset.
    clear_prog(OP_NOP);
    prog[0] = enc(OP_LDR, 1'b1, 6'd33);
    prog[1] = enc(OP_HLT, 1'b0, 6'd0);
    wait_cycles = 1000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    expect_val("mid_req_waiting", 1);
    expect_val("mid_req_in_rst", 0);
    expect_val("late_req_first", 0);
    expect_val("late_pc", 0);
    expect_val("late_fetches", 0);
    expect_val("late_req_again", 1);
    expect_val("late_acc", 0);
    expect_val("recover_acc", 33);
    expect_val("recover_halted", 1);
    observe("mid_req_waiting", imem_req);
    rst_n = 1'b0;
    #1;
    observe("mid_req_in_rst", imem_req);
    fetch_t.delete();
    @(negedge clk);
    rst_n = 1'b1;
    valid_pulse = 1'b1;
    #1;
    observe("late_req_first", imem_req);
    @(negedge clk);
    valid_pulse = 1'b0;
    repeat (3) @(negedge clk);
    observe("late_pc", pc);
    observe("late_fetches", fetch_t.size());
    observe("late_req_again", imem_req);
    observe("late_acc", acc);
    wait_cycles = 0;
    run_halt(200);
    observe("recover_acc", acc);
    observe("recover_halted", halted);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
